// File: rtl/csa_26bits_operand_recover_seq_if.sv
// Request/response bundle for the operand-recovery block: operands and start
// in, busy/done status and the recovered operand with its flags out.
interface csa_26bits_operand_recover_seq_if #(
    parameter int SUM_W = 27,
    parameter int OP_W  = 26
);
    logic             start;
    logic [SUM_W-1:0] sum_input;
    logic [OP_W-1:0]  a_input;
    logic             busy;
    logic             done;
    logic [OP_W-1:0]  b_output;
    logic             borrow_out;
    logic             overflow;

    modport master (
        output start, sum_input, a_input,
        input  busy, done, b_output, borrow_out, overflow
    );

    modport slave (
        input  start, sum_input, a_input,
        output busy, done, b_output, borrow_out, overflow
    );
endinterface

// File: rtl/csa_26bits_operand_recover_seq.sv
// Chunk-serial subtractor recovering b = sum - a from a carry-select adder
// result, flagging sums that could not have come from a 26-bit add.
//
// state | meaning
// IDLE  | waiting for start; results from the last operation held
// BUSY  | subtracting one CHUNK_W slice per falling edge, lowest first
// DONE  | one-cycle done pulse; returns to IDLE unconditionally
module csa_26bits_operand_recover_seq #(
    parameter int SUM_W   = 27,
    parameter int OP_W    = 26,
    parameter int CHUNK_W = 9
) (
    input  logic                               clk,
    input  logic                               reset,
    csa_26bits_operand_recover_seq_if.slave    bus
);
    localparam int NCHUNK = (SUM_W + CHUNK_W - 1) / CHUNK_W;
    localparam int PAD_W  = NCHUNK * CHUNK_W;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Operands are zero-padded to a whole number of chunks so the top chunk
    // needs no special truncation logic.
    logic [PAD_W-1:0]   s_reg;
    logic [PAD_W-1:0]   a_reg;
    logic [PAD_W-1:0]   d_reg;
    logic [PAD_W-1:0]   d_next;
    logic               borrow_reg;
    logic [KW-1:0]      k_reg;
    logic [CHUNK_W-1:0] s_chunk;
    logic [CHUNK_W-1:0] a_chunk;
    logic [CHUNK_W:0]   diff;
    logic               bw;
    logic               last_chunk;
    logic [OP_W-1:0]    b_reg;
    logic               borrow_out_reg;
    logic               overflow_reg;

    assign last_chunk = (k_reg == KW'(NCHUNK - 1));

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = BUSY;
            BUSY:    if (last_chunk) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_chunk = '0;
        a_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (k_reg == KW'(i)) begin
                s_chunk = s_reg[i*CHUNK_W +: CHUNK_W];
                a_chunk = a_reg[i*CHUNK_W +: CHUNK_W];
            end
        end
        diff = {1'b0, s_chunk} - {1'b0, a_chunk} - {{CHUNK_W{1'b0}}, borrow_reg};
        bw   = diff[CHUNK_W];
        d_next = d_reg;
        for (int i = 0; i < NCHUNK; i++) begin
            if (k_reg == KW'(i)) begin
                d_next[i*CHUNK_W +: CHUNK_W] = diff[CHUNK_W-1:0];
            end
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            s_reg          <= '0;
            a_reg          <= '0;
            d_reg          <= '0;
            borrow_reg     <= 1'b0;
            k_reg          <= '0;
            b_reg          <= '0;
            borrow_out_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        s_reg      <= PAD_W'(bus.sum_input);
                        a_reg      <= PAD_W'(bus.a_input);
                        d_reg      <= '0;
                        borrow_reg <= 1'b0;
                        k_reg      <= '0;
                    end
                end
                BUSY: begin
                    d_reg      <= d_next;
                    borrow_reg <= bw;
                    if (last_chunk) begin
                        k_reg          <= '0;
                        b_reg          <= d_next[OP_W-1:0];
                        borrow_out_reg <= bw;
                        overflow_reg   <= d_next[SUM_W-1] & ~bw;
                    end else begin
                        k_reg <= k_reg + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (state_q == BUSY);
    assign bus.done       = (state_q == DONE);
    assign bus.b_output   = b_reg;
    assign bus.borrow_out = borrow_out_reg;
    assign bus.overflow   = overflow_reg;
endmodule
